answer_gen: RTL and testbench

ANSWER_GEN -- requirements
Module: answer_gen

---
 rtl/answer_gen_pkg.sv | 19 +
 rtl/answer_gen_lfsr16.sv | 35 +++
 rtl/answer_gen.sv | 98 +++++++++
 tb/tb_answer_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/answer_gen_pkg.sv
// Shared definitions for the answer generator: FSM encoding, LFSR taps,
// default seed and the single-step LFSR function.
package answer_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PICK = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois right-shift step; a non-zero state never reaches zero
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/answer_gen_lfsr16.sv
// 16-bit Galois LFSR that steps every cycle; a load replaces the step, and a
// zero seed is swapped for SEED so the register never locks up at zero.
module lfsr16
  import answer_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [3:0]  nibble
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  always_comb begin
    lfsr_next = lfsr_step(lfsr_reg);
    if (load) begin
      lfsr_next = (seed == 16'h0000) ? SEED : seed;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign nibble = lfsr_reg[3:0];

endmodule

// File: rtl/answer_gen.sv
// Builds a four-digit answer of distinct digits (each <= MAX_DIGIT) by
// drawing LFSR nibbles and rejecting out-of-range or repeated candidates.
module answer_gen
  import answer_gen_pkg::*;
#(
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter logic [3:0]  MAX_DIGIT = 4'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        ack,
  output logic [15:0] answer,
  output logic        valid,
  output logic        busy,
  output logic [7:0]  rejects
);

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  idx_reg;
  logic [15:0] answer_reg;
  logic [7:0]  rejects_reg;
  logic [3:0]  cand;
  logic [3:0]  dup;
  logic        accept;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (seed_load && (state_reg == ST_IDLE)),
    .seed   (seed),
    .nibble (cand)
  );

  // Slot gi holds the gi-th accepted digit; only filled slots can collide
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dup
      assign dup[gi] = (2'(gi) < idx_reg) && (answer_reg[15-4*gi -: 4] == cand);
    end
  endgenerate

  assign accept = (cand <= MAX_DIGIT) && (dup == 4'b0000);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req) state_next = ST_PICK;
      ST_PICK: if (accept && (idx_reg == 2'd3)) state_next = ST_DONE;
      ST_DONE: if (ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg     <= 2'd0;
      answer_reg  <= 16'h0000;
      rejects_reg <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            idx_reg     <= 2'd0;
            answer_reg  <= 16'h0000;
            rejects_reg <= 8'h00;
          end
        end
        ST_PICK: begin
          if (accept) begin
            answer_reg[{~idx_reg, 2'b00} +: 4] <= cand;
            idx_reg                            <= idx_reg + 2'd1;
          end else if (rejects_reg != 8'hFF) begin
            rejects_reg <= rejects_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign answer  = answer_reg;
  assign rejects = rejects_reg;
  assign busy    = (state_reg == ST_PICK);
  assign valid   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_answer_gen.sv
// Scoreboard bench: two instances (default and SEED=1234/MAX_DIGIT=3); expected
// answers are queued at request time and checked when valid rises.
`timescale 1ns/1ps
module tb_answer_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, req_v, load_v, ack_v;
  logic [15:0] seed_v    [2];
  logic [15:0] answer_v  [2];
  logic [1:0]  valid_v, busy_v;
  logic [7:0]  rejects_v [2];

  answer_gen dut_a (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .seed_load(load_v[0]), .seed(seed_v[0]),
    .ack(ack_v[0]), .answer(answer_v[0]), .valid(valid_v[0]), .busy(busy_v[0]),
    .rejects(rejects_v[0])
  );

  answer_gen #(.SEED(16'h1234), .MAX_DIGIT(4'd3)) dut_b (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .seed_load(load_v[1]), .seed(seed_v[1]),
    .ack(ack_v[1]), .answer(answer_v[1]), .valid(valid_v[1]), .busy(busy_v[1]),
    .rejects(rejects_v[1])
  );

  typedef struct {
    logic [15:0] ans;
    logic [7:0]  rej;
    int          cycles;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] mdl      [2];
  logic [15:0] last_exp [2];
  logic [15:0] first_b;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_par(input int i);
    return (i == 0) ? 16'hACE1 : 16'h1234;
  endfunction

  function automatic logic [3:0] max_par(input int i);
    return (i == 0) ? 4'd9 : 4'd3;
  endfunction

  // Reference: draw nibbles from l1 onward until four distinct in-range digits
  function automatic exp_t predict(input logic [15:0] l1, input logic [3:0] maxd);
    exp_t        e;
    logic [3:0]  d [4];
    int          k;
    logic        ok;
    logic [15:0] l;
    d        = '{default: 4'd0};
    k        = 0;
    l        = l1;
    e.rej    = 8'd0;
    e.cycles = 0;
    while (k < 4 && e.cycles < 5000) begin
      e.cycles++;
      ok = (l[3:0] <= maxd);
      for (int j = 0; j < k; j++) if (d[j] == l[3:0]) ok = 1'b0;
      if (ok) begin
        d[k] = l[3:0];
        k++;
      end else if (e.rej != 8'hFF) begin
        e.rej = e.rej + 8'd1;
      end
      l = step(l);
    end
    e.ans = {d[0], d[1], d[2], d[3]};
    return e;
  endfunction

  function automatic logic digits_ok(input logic [15:0] a, input logic [3:0] maxd);
    logic r;
    r = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (a[4*p +: 4] > maxd) r = 1'b0;
      for (int q = p + 1; q < 4; q++) if (a[4*p +: 4] == a[4*q +: 4]) r = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_v[i])      mdl[i] <= seed_par(i);
      else if (load_v[i]) mdl[i] <= (seed_v[i] == 16'h0000) ? seed_par(i) : seed_v[i];
      else                mdl[i] <= step(mdl[i]);
    end
  end

  // Monitor: pops one expectation per rising edge of valid
  logic [1:0] vprev;
  int         pick_cnt [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_v[i]) begin
        pick_cnt[i] = 0;
        vprev[i]    = 1'b0;
      end else begin
        if (busy_v[i]) pick_cnt[i]++;
        if (valid_v[i] && !vprev[i]) begin
          exp_t e;
          bit   have;
          have = 1'b0;
          if (i == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
          else if (i == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
          if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid[%0d]: answer %h with nothing expected", i, answer_v[i]);
          end else begin
            chk($sformatf("answer[%0d]", i), 32'(answer_v[i]), 32'(e.ans));
            chk($sformatf("rejects[%0d]", i), 32'(rejects_v[i]), 32'(e.rej));
            chk($sformatf("pick_cycles[%0d]", i), 32'(pick_cnt[i]), 32'(e.cycles));
            chk($sformatf("digits_ok[%0d]", i), 32'(digits_ok(answer_v[i], max_par(i))), 32'd1);
          end
          pick_cnt[i] = 0;
        end
        vprev[i] = valid_v[i];
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input int i);
    logic [15:0] l1;
    exp_t        e;
    if (load_v[i]) l1 = (seed_v[i] == 16'h0000) ? seed_par(i) : seed_v[i];
    else           l1 = step(mdl[i]);
    e = predict(l1, max_par(i));
    if (i == 0) q_a.push_back(e); else q_b.push_back(e);
    last_exp[i] = e.ans;
    req_v[i] = 1'b1;
    tick(1);
    req_v[i]  = 1'b0;
    load_v[i] = 1'b0;
    chk($sformatf("busy_after_req[%0d]", i), 32'(busy_v[i]), 32'd1);
    chk($sformatf("valid_after_req[%0d]", i), 32'(valid_v[i]), 32'd0);
  endtask

  task automatic wait_valid(input int i, input int lim);
    int c;
    c = 0;
    while (!valid_v[i] && c < lim) begin
      tick(1);
      c++;
    end
    if (!valid_v[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_valid[%0d]: valid 0 after %0d cycles, required 1", i, lim);
    end
  endtask

  task automatic do_ack(input int i);
    ack_v[i] = 1'b1;
    tick(1);
    ack_v[i] = 1'b0;
    chk($sformatf("ack_valid[%0d]", i), 32'(valid_v[i]), 32'd0);
    chk($sformatf("ack_answer[%0d]", i), 32'(answer_v[i]), 32'(last_exp[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_v = 2'b00; req_v = 2'b00; load_v = 2'b00; ack_v = 2'b00;
    seed_v[0] = 16'h0000; seed_v[1] = 16'h0000;
    tick(3);

    chk("rst_answer", 32'(answer_v[0]), 32'h0);
    chk("rst_valid", 32'(valid_v[0]), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_rejects", 32'(rejects_v[0]), 32'd0);
    chk("rst_lfsr", 32'(dut_a.u_lfsr.lfsr_reg), 32'hACE1);

    rst_v[0] = 1'b1;
    tick(1);
    chk("lfsr_first_step", 32'(dut_a.u_lfsr.lfsr_reg), 32'hE270);

    load_v[0] = 1'b1; seed_v[0] = 16'h0000;
    tick(1);
    load_v[0] = 1'b0;
    chk("lfsr_zero_seed", 32'(dut_a.u_lfsr.lfsr_reg), 32'hACE1);
    chk("zero_seed_valid", 32'(valid_v[0]), 32'd0);
    chk("zero_seed_busy", 32'(busy_v[0]), 32'd0);

    load_v[0] = 1'b1; seed_v[0] = 16'hBEEF;
    tick(1);
    load_v[0] = 1'b0;
    chk("lfsr_seed_load", 32'(dut_a.u_lfsr.lfsr_reg), 32'hBEEF);

    issue_req(0);
    wait_valid(0, 300);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("hold_valid", 32'(valid_v[0]), 32'd1);
      chk("hold_answer", 32'(answer_v[0]), 32'(last_exp[0]));
    end
    do_ack(0);
    tick(2);
    chk("idle_answer_held", 32'(answer_v[0]), 32'(last_exp[0]));

    load_v[0] = 1'b1; seed_v[0] = 16'h5A5A;
    issue_req(0);
    wait_valid(0, 300);
    do_ack(0);

    issue_req(0);
    c = 0;
    while (dut_a.idx_reg != 2'd2 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("two_digits_reached", 32'(dut_a.idx_reg), 32'd2);
    rst_v[0] = 1'b0;
    #1;
    chk("midpick_rst_answer", 32'(answer_v[0]), 32'h0);
    chk("midpick_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("midpick_rst_valid", 32'(valid_v[0]), 32'd0);
    chk("midpick_rst_idx", 32'(dut_a.idx_reg), 32'd0);
    q_a.delete();
    tick(1);
    rst_v[0] = 1'b1;
    issue_req(0);
    wait_valid(0, 300);
    do_ack(0);

    rst_v[1] = 1'b1;
    issue_req(1);
    first_b = last_exp[1];
    wait_valid(1, 300);
    do_ack(1);
    issue_req(1);
    wait_valid(1, 300);
    do_ack(1);

    rst_v[1] = 1'b0;
    tick(2);
    rst_v[1] = 1'b1;
    issue_req(1);
    wait_valid(1, 300);
    chk("rerun_same_answer", 32'(answer_v[1]), 32'(first_b));
    do_ack(1);

    issue_req(1);
    req_v[1] = 1'b1;
    tick(1);
    req_v[1] = 1'b0;
    wait_valid(1, 300);
    req_v[1] = 1'b1;
    tick(1);
    req_v[1] = 1'b0;
    chk("done_req_valid", 32'(valid_v[1]), 32'd1);
    chk("done_req_busy", 32'(busy_v[1]), 32'd0);
    chk("done_req_answer", 32'(answer_v[1]), 32'(last_exp[1]));
    do_ack(1);

    tick(5);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
